// File: rtl/flash_audio_pkg.sv
// Shared types and constants for the flash-backed audio sample sequencer.
package flash_audio_pkg;

    localparam int FLASH_WORD_W = 32;
    localparam int SAMPLE_W     = 16;

    // Default playback window: the first 512K words of flash.
    localparam int          DEF_ADDR_W     = 23;
    localparam logic [22:0] DEF_START_ADDR = 23'h000000;
    localparam logic [22:0] DEF_END_ADDR   = 23'h07FFFF;

    // Sequencer states. The numeric encoding is visible on the fsm_state debug port.
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_REQ         = 3'd1,
        ST_WAIT_DATA   = 3'd2,
        ST_FIRST_HALF  = 3'd3,
        ST_SECOND_HALF = 3'd4,
        ST_ADVANCE     = 3'd5
    } state_e;

endpackage

// File: rtl/flash_tick_tracker.sv
// Tracks one outstanding sample tick, drops ticks while paused, and flags
// ticks lost because one was already waiting.
module flash_tick_tracker (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_tick,
    input  logic pause,
    input  logic consume,
    output logic tick_avail,
    output logic overrun
);

    logic tick_pending;

    // A tick is usable this cycle if one is stored or one is arriving now.
    assign tick_avail = ~pause & (tick_pending | sample_tick);

    // Pending flag is one deep; a consuming cycle takes the stored tick first,
    // so a tick arriving in that same cycle becomes the new pending one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_pending <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= ~pause & ~consume & sample_tick & tick_pending;
            if (pause) begin
                tick_pending <= 1'b0;
            end else if (consume) begin
                tick_pending <= tick_pending & sample_tick;
            end else if (sample_tick) begin
                tick_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/flash_sample_sequencer.sv
// Fetches 32-bit flash words over an Avalon-style read port and plays each
// word out as two 16-bit samples, one per sample tick.
//
// Read handshake: flash_mem_read is held high with a stable flash_mem_address
// until a cycle in which flash_mem_waitrequest is low; that cycle accepts the
// request and read drops on the next cycle. Exactly one flash_mem_readdatavalid
// pulse later returns the word; it is only honoured in WAIT_DATA.
module flash_sample_sequencer
    import flash_audio_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = DEF_START_ADDR,
    parameter logic [ADDR_W-1:0] END_ADDR   = DEF_END_ADDR
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    pause,
    input  logic                    direction,
    input  logic                    restart,
    input  logic                    sample_tick,
    output logic                    flash_mem_read,
    output logic [ADDR_W-1:0]       flash_mem_address,
    input  logic                    flash_mem_waitrequest,
    input  logic                    flash_mem_readdatavalid,
    input  logic [FLASH_WORD_W-1:0] flash_mem_readdata,
    output logic [SAMPLE_W-1:0]     audio_data,
    output logic                    sample_valid,
    output logic                    overrun,
    output logic [2:0]              fsm_state
);

    localparam logic [2:0] IDLE        = ST_IDLE;
    localparam logic [2:0] REQ         = ST_REQ;
    localparam logic [2:0] WAIT_DATA   = ST_WAIT_DATA;
    localparam logic [2:0] FIRST_HALF  = ST_FIRST_HALF;
    localparam logic [2:0] SECOND_HALF = ST_SECOND_HALF;
    localparam logic [2:0] ADVANCE     = ST_ADVANCE;

    logic [2:0]              state;
    logic [ADDR_W-1:0]       addr;
    logic [FLASH_WORD_W-1:0] word;
    logic                    restart_pending;
    logic                    tick_avail;
    logic                    consume;
    logic                    take_upper;
    logic [SAMPLE_W-1:0]     half_sample;
    logic [ADDR_W-1:0]       reload_addr;

    // Next word address in the playback direction, wrapping inside the window.
    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                    input logic backward);
        if (backward) return (a == START_ADDR) ? END_ADDR : a - ADDR_W'(1);
        return (a == END_ADDR) ? START_ADDR : a + ADDR_W'(1);
    endfunction

    // Ticks are only taken while a word is loaded and playback is enabled.
    assign consume = enable & tick_avail & ((state == FIRST_HALF) | (state == SECOND_HALF));

    // Forward plays low half first; backward plays high half first.
    assign take_upper  = direction ^ (state == SECOND_HALF);
    assign half_sample = take_upper ? word[31:16] : word[15:0];
    assign reload_addr = direction ? END_ADDR : START_ADDR;

    assign flash_mem_read    = (state == REQ);
    assign flash_mem_address = addr;
    assign fsm_state         = state;

    flash_tick_tracker u_tick (
        .clk         (CLK),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .pause       (pause),
        .consume     (consume),
        .tick_avail  (tick_avail),
        .overrun     (overrun)
    );

    // Main sequencer: fetch, play two halves, step the address.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            addr            <= START_ADDR;
            word            <= '0;
            audio_data      <= '0;
            sample_valid    <= 1'b0;
            restart_pending <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (restart) restart_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (restart | restart_pending) begin
                        addr            <= reload_addr;
                        restart_pending <= 1'b0;
                    end
                    if (enable) state <= REQ;
                end
                REQ: begin
                    if (!flash_mem_waitrequest) state <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (flash_mem_readdatavalid) begin
                        if (enable) begin
                            word  <= flash_mem_readdata;
                            state <= FIRST_HALF;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FIRST_HALF: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (consume) begin
                        audio_data   <= half_sample;
                        sample_valid <= 1'b1;
                        state        <= SECOND_HALF;
                    end
                end
                SECOND_HALF: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (consume) begin
                        audio_data   <= half_sample;
                        sample_valid <= 1'b1;
                        state        <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (restart | restart_pending) begin
                        addr            <= reload_addr;
                        restart_pending <= 1'b0;
                    end else begin
                        addr <= step_addr(addr, direction);
                    end
                    state <= enable ? REQ : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/flash_sample_sequencer.md
Name: flash_sample_sequencer

Overview:
Sequences 32-bit word reads from the on-board flash through its Avalon-style read port and turns each word into two 16-bit audio samples, one per sample tick. Sits between the flash controller and the audio output path. Handles play/pause, forward/backward direction, wrap-around over a configurable word-address window, and restart. Keeps exactly one word prefetched so samples are emitted on the tick edge.

Parameters:
ADDR_W, 23, flash word-address width
START_ADDR, 23'h000000, first word address of the playback window
END_ADDR, 23'h07FFFF, last word address of the playback window (inclusive, END_ADDR >= START_ADDR)

Ports:
CLK  in  1  system clock, 50 MHz
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  level; 1 = run, 0 = finish any bus transaction, then idle
pause  in  1  level; 1 = ignore sample ticks, hold position
direction  in  1  0 = forward, 1 = backward
restart  in  1  one-cycle pulse; jump to window start (forward) or end (backward)
sample_tick  in  1  one-cycle pulse, already synchronised to CLK
flash_mem_read  out  1  read request to flash controller
flash_mem_address  out  ADDR_W  word address of request
flash_mem_waitrequest  in  1  controller stall
flash_mem_readdatavalid  in  1  read data strobe
flash_mem_readdata  in  32  read data
audio_data  out  16  current sample, held between ticks
sample_valid  out  1  one-cycle pulse when audio_data updates
overrun  out  1  one-cycle pulse when a tick is dropped

Behaviour:
- Reset (async, rst_n=0): state=IDLE, addr=START_ADDR, flash_mem_read=0, audio_data=0, sample_valid=0, overrun=0, tick_pending=0, restart_pending=0, word register=0.
- States: IDLE, REQ, WAIT_DATA, FIRST_HALF, SECOND_HALF, ADVANCE.
- IDLE: enable=1 -> REQ next cycle.
- REQ: flash_mem_read=1, flash_mem_address=addr; stay while waitrequest=1; waitrequest=0 -> WAIT_DATA. Read drops the cycle after acceptance.
- WAIT_DATA: readdatavalid=1 -> latch readdata into word register -> FIRST_HALF. Data arriving in REQ is illegal; ignored.
- FIRST_HALF: on consumed tick (tick_pending or sample_tick, and pause=0): audio_data <= word[15:0] if forward, word[31:16] if backward; sample_valid=1 the following cycle; -> SECOND_HALF.
- SECOND_HALF: on consumed tick: other half (forward word[31:16], backward word[15:0]); -> ADVANCE.
- ADVANCE (1 cycle): restart_pending -> addr=START_ADDR (forward) or END_ADDR (backward), clear pending; else forward: addr==END_ADDR ? START_ADDR : addr+1; backward: addr==START_ADDR ? END_ADDR : addr-1. Then enable=1 -> REQ, else IDLE.
- direction sampled per half in FIRST/SECOND_HALF; a change mid-word affects the order of the next half and the next ADVANCE only.
- Tick handling: sample_tick outside a consuming cycle sets tick_pending (1 deep). Tick while tick_pending=1 and not consumed -> overrun pulse, tick dropped. pause=1: incoming ticks are discarded (no pending, no overrun), tick_pending cleared.
- restart: sets restart_pending in any state; in IDLE applied immediately (addr reloaded). Never aborts a bus transaction.
- enable=0 in REQ/WAIT_DATA: transaction completes, then -> IDLE; word discarded, addr unchanged. enable=0 in FIRST/SECOND_HALF -> IDLE; addr unchanged (word re-fetched on resume).
- Reset mid-transaction: read deasserts immediately; a late readdatavalid after reset is ignored (IDLE).
- sample_valid and overrun are registered single-cycle pulses.

Decomposition:
- Package flash_audio_pkg: state enum typedef, FLASH_WORD_W=32, SAMPLE_W=16, default window constants.
- Sub-module flash_tick_tracker: pending-tick flag, pause discard, overrun pulse. Everything else stays in one FSM module.

Test Plan:
- Reset, enable=1, flash word @0 = 32'h1234ABCD, forward, two ticks -> flash_mem_address=0 read once; audio_data 16'hABCD then 16'h1234, two sample_valid pulses; next read address 1.
- Same word, direction=1 from reset with restart -> first read at END_ADDR; samples upper then lower; next address END_ADDR-1.
- Forward at addr=END_ADDR, two ticks -> next read address START_ADDR (wrap); backward at START_ADDR -> END_ADDR.
- waitrequest held 5 cycles, readdatavalid 3 cycles later -> read held high exactly 6 cycles, address stable, one latch.
- pause=1, 4 ticks -> no sample_valid, no overrun, address unchanged; release pause and one tick -> resumes with next half.
- Three ticks during a slow fetch -> first pending, overrun pulses twice, one sample emitted on entry to FIRST_HALF; restart pulse mid-fetch -> fetch completes, next ADVANCE loads START_ADDR.
